pla_sweep_ctrl: RTL and testbench

Sequencer that exhaustively drives a 6-input, 1-output combinational PLA function block (x0..x5 -> y0) through all 64 input minterms. It captures the response into a 64-bit truth table and compares it bit-for-bit against a golden table. It sits between the D-reduction test harness and the function under test. Results are reported through a start/busy/done handshake with a results-valid flag.

---
 rtl/pla_sweep_ctrl.sv | 133 +++++++++++++
 tb/tb_pla_sweep_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pla_sweep_ctrl.sv
// Exhaustive sweep sequencer for a 6-input, 1-output PLA function block.
// Drives every minterm, captures y0 into a truth table and scores it against a golden table.
module pla_sweep_ctrl #(
  parameter int N_IN   = 6,
  parameter int SETTLE = 1,
  localparam int TT_W  = 2 ** N_IN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [TT_W-1:0]   golden,
  output logic [N_IN-1:0]   x_out,
  input  logic              y_in,
  output logic              busy,
  output logic              done,
  output logic              valid,
  output logic [TT_W-1:0]   tt,
  output logic [N_IN:0]     ones_cnt,
  output logic [N_IN:0]     err_cnt,
  output logic              mismatch,
  output logic [N_IN-1:0]   first_err_idx
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE);
  localparam logic [N_IN-1:0] IDX_LAST    = '1;
  localparam logic [N_IN-1:0] IDX_ONE     = N_IN'(1);
  localparam logic [N_IN:0]   CNT_ONE     = (N_IN + 1)'(1);

  state_t          state;
  state_t          state_nx;
  logic [TT_W-1:0] golden_q;
  logic [3:0]      settle_cnt;

  logic accept;
  logic quit;
  logic capture;
  logic last_vec;
  logic y_err;

  // A start in IDLE outranks a simultaneous abort; abort only acts while sweeping.
  assign accept   = (state == IDLE) && start;
  assign quit     = (state == SWEEP) && abort;
  assign capture  = (state == SWEEP) && !abort && (settle_cnt == SETTLE_LAST);
  assign last_vec = (x_out == IDX_LAST);
  assign y_err    = (y_in != golden_q[x_out]);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // NOTE: default assignment first so no path through the case infers a latch.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = SWEEP;
      SWEEP: begin
        if (abort)                    state_nx = IDLE;
        else if (capture && last_vec) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SWEEP);
    done = (state == DONE);
  end

  // NOTE: the truth table is plain flops, not a RAM, so it is cleared by reset like any register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      golden_q      <= '0;
      x_out         <= '0;
      settle_cnt    <= '0;
      valid         <= 1'b0;
      tt            <= '0;
      ones_cnt      <= '0;
      err_cnt       <= '0;
      mismatch      <= 1'b0;
      first_err_idx <= '0;
    end else if (accept) begin
      golden_q      <= golden;
      x_out         <= '0;
      settle_cnt    <= '0;
      valid         <= 1'b0;
      tt            <= '0;
      ones_cnt      <= '0;
      err_cnt       <= '0;
      mismatch      <= 1'b0;
      first_err_idx <= '0;
    end else if (quit) begin
      // Partial results stay visible but are flagged as not valid.
      x_out      <= '0;
      settle_cnt <= '0;
      valid      <= 1'b0;
    end else if (state == SWEEP) begin
      if (capture) begin
        tt[x_out] <= y_in;
        if (y_in) ones_cnt <= ones_cnt + CNT_ONE;
        if (y_err) begin
          err_cnt  <= err_cnt + CNT_ONE;
          mismatch <= 1'b1;
          if (!mismatch) first_err_idx <= x_out;
        end
        settle_cnt <= '0;
        if (last_vec) begin
          // Index parks at 0 for the DONE cycle instead of wrapping.
          x_out <= '0;
          valid <= 1'b1;
        end else begin
          x_out <= x_out + IDX_ONE;
        end
      end else begin
        settle_cnt <= settle_cnt + 4'd1;
      end
    end
  end

  a_done_valid : assert property (@(posedge clk) disable iff (!rst_n) done |-> (valid && !busy));
  a_idle_x0    : assert property (@(posedge clk) disable iff (!rst_n) !busy |-> (x_out == '0));
  a_err_bound  : assert property (@(posedge clk) disable iff (!rst_n) (err_cnt != '0) == mismatch);

endmodule

// File: tb/tb_pla_sweep_ctrl.sv
// Scoreboard bench for pla_sweep_ctrl: two instances (SETTLE=1 and SETTLE=0), directed sweeps,
// expected results queued at start and checked by monitors on each done pulse.
module tb_pla_sweep_ctrl;

  typedef struct {
    logic [63:0] tt;
    logic [6:0]  ones;
    logic [6:0]  errs;
    logic        mm;
    logic [5:0]  first;
    int          done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance with SETTLE=1 (suffix 1) and SETTLE=0 (suffix 0).
  logic        s1 = 0, a1 = 0, y1, busy1, done1, valid1, mm1;
  logic [63:0] g1 = '0, tt1;
  logic [5:0]  x1, first1;
  logic [6:0]  ones1, err1;
  logic [1:0]  ysel1 = 2'd0;

  logic        s0 = 0, a0 = 0, y0, busy0, done0, valid0, mm0;
  logic [63:0] g0 = '0, tt0;
  logic [5:0]  x0, first0;
  logic [6:0]  ones0, err0;
  logic [1:0]  ysel0 = 2'd0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t q1[$];
  exp_t q0[$];
  logic [63:0] pla_tab;

  // Reference PLA: sum of products over x0..x5.
  function automatic logic pla_f(input logic [5:0] x);
    return (x[0] & x[1] & ~x[2]) | (~x[3] & x[4]) | (x[5] & x[0] & ~x[4]);
  endfunction

  function automatic logic ysrc(input logic [1:0] sel, input logic [5:0] x);
    case (sel)
      2'd0:    return x[0];
      2'd1:    return 1'b1;
      default: return pla_f(x);
    endcase
  endfunction

  assign y1 = ysrc(ysel1, x1);
  assign y0 = ysrc(ysel0, x0);

  pla_sweep_ctrl #(.N_IN(6), .SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(s1), .abort(a1), .golden(g1), .x_out(x1), .y_in(y1),
    .busy(busy1), .done(done1), .valid(valid1), .tt(tt1), .ones_cnt(ones1), .err_cnt(err1),
    .mismatch(mm1), .first_err_idx(first1)
  );

  pla_sweep_ctrl #(.N_IN(6), .SETTLE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(s0), .abort(a0), .golden(g0), .x_out(x0), .y_in(y0),
    .busy(busy0), .done(done0), .valid(valid0), .tt(tt0), .ones_cnt(ones0), .err_cnt(err0),
    .mismatch(mm0), .first_err_idx(first0)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic score(input string tag, input exp_t e, input logic [63:0] tt,
                       input logic [6:0] ones, input logic [6:0] errs, input logic mm,
                       input logic [5:0] first, input logic valid, input logic busy);
    check({tag, "_tt"},         tt,              e.tt);
    check({tag, "_ones_cnt"},   64'(ones),       64'(e.ones));
    check({tag, "_err_cnt"},    64'(errs),       64'(e.errs));
    check({tag, "_mismatch"},   64'(mm),         64'(e.mm));
    check({tag, "_first_err"},  64'(first),      64'(e.first));
    check({tag, "_valid"},      64'(valid),      64'd1);
    check({tag, "_busy"},       64'(busy),       64'd0);
    check({tag, "_done_cycle"}, 64'(cyc),        64'(e.done_cyc));
  endtask

  // Monitors: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && done1) begin
      if (q1.size() == 0) check("dut1_spurious_done", 64'(done1), 64'd0);
      else score("dut1", q1.pop_front(), tt1, ones1, err1, mm1, first1, valid1, busy1);
    end
  end

  always @(negedge clk) begin
    if (rst_n && done0) begin
      if (q0.size() == 0) check("dut0_spurious_done", 64'(done0), 64'd0);
      else score("dut0", q0.pop_front(), tt0, ones0, err0, mm0, first0, valid0, busy0);
    end
  end

  // Issue a start on one instance and queue its hand-computed result.
  task automatic launch(input bit slow, input logic [63:0] gold, input logic [63:0] exp_tt,
                        input int ones, input int errs, input int first, input bit with_abort);
    exp_t e;
    @(negedge clk);
    e.tt       = exp_tt;
    e.ones     = 7'(ones);
    e.errs     = 7'(errs);
    e.mm       = (errs != 0);
    e.first    = 6'(first);
    e.done_cyc = cyc + 1 + (slow ? 128 : 64);
    if (slow) begin
      g1 = gold; s1 = 1'b1; a1 = with_abort; q1.push_back(e);
    end else begin
      g0 = gold; s0 = 1'b1; a0 = with_abort; q0.push_back(e);
    end
    @(negedge clk);
    s1 = 1'b0; a1 = 1'b0; s0 = 1'b0; a0 = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && (q1.size() != 0 || q0.size() != 0); i++) @(negedge clk);
    if (q1.size() != 0 || q0.size() != 0) begin
      check("drain_timeout", 64'(q1.size() + q0.size()), 64'd0);
      q1.delete();
      q0.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_x1(input logic [5:0] target);
    int i;
    for (i = 0; i < 300 && x1 != target; i++) @(negedge clk);
    check("wait_x1_reached", 64'(x1), 64'(target));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 64; i++) pla_tab[i] = pla_f(6'(i));

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_x_out",  64'(x1), 64'd0);
    check("rst_busy",   64'(busy1), 64'd0);
    check("rst_done",   64'(done1), 64'd0);
    check("rst_valid",  64'(valid1), 64'd0);
    check("rst_tt",     tt1, 64'd0);
    check("rst_counts", {ones1, err1, mm1, first1}, 64'd0);
    check("rst_dut0",   {x0, busy0, done0, valid0, ones0, err0, mm0, first0}, 64'd0);
    rst_n = 1'b1;

    // T1: y = x0, matching golden
    ysel1 = 2'd0;
    launch(1'b1, 64'hAAAA_AAAA_AAAA_AAAA, 64'hAAAA_AAAA_AAAA_AAAA, 32, 0, 0, 1'b0);
    check("t1_busy_after_start", 64'(busy1), 64'd1);
    drain();
    repeat (3) @(negedge clk);
    a1 = 1'b1;                      // abort in IDLE has no effect
    @(negedge clk);
    a1 = 1'b0;
    check("t1_hold_valid", 64'(valid1), 64'd1);
    check("t1_hold_tt",    tt1, 64'hAAAA_AAAA_AAAA_AAAA);

    // T2: golden bits 5 and 40 flipped; start raised together with abort
    launch(1'b1, 64'hAAAA_AAAA_AAAA_AAAA ^ (64'd1 << 5) ^ (64'd1 << 40),
           64'hAAAA_AAAA_AAAA_AAAA, 32, 2, 5, 1'b1);
    check("t2_start_beats_abort", 64'(busy1), 64'd1);
    check("t2_valid_cleared",     64'(valid1), 64'd0);
    drain();

    // T3: y tied 1, golden 0, SETTLE=0
    ysel0 = 2'd1;
    launch(1'b0, 64'd0, '1, 64, 64, 0, 1'b0);
    drain();

    // T3b: PLA with golden bit 63 wrong; start pulsed in the DONE cycle is ignored
    ysel0 = 2'd2;
    launch(1'b0, pla_tab ^ (64'd1 << 63), pla_tab, $countones(pla_tab), 1, 63, 1'b0);
    begin
      int i;
      for (i = 0; i < 200 && !done0; i++) @(negedge clk);
      check("t3b_done_seen", 64'(done0), 64'd1);
    end
    s0 = 1'b1;
    @(negedge clk);
    s0 = 1'b0;
    check("t3b_start_in_done_ignored", 64'(busy0), 64'd0);
    drain();

    // T4: abort at x_out = 20
    ysel1 = 2'd0;
    @(negedge clk);
    g1 = 64'hAAAA_AAAA_AAAA_AAAA; s1 = 1'b1;
    @(negedge clk);
    s1 = 1'b0;
    wait_x1(6'd20);
    a1 = 1'b1;
    @(negedge clk);
    a1 = 1'b0;
    check("t4_busy",     64'(busy1), 64'd0);
    check("t4_x_out",    64'(x1), 64'd0);
    check("t4_valid",    64'(valid1), 64'd0);
    check("t4_tt_part",  tt1, 64'h0000_0000_000A_AAAA);
    check("t4_ones_part", 64'(ones1), 64'd10);
    repeat (150) @(negedge clk);
    check("t4_stays_idle", 64'(busy1), 64'd0);

    // T5: second start mid-sweep must not restart it
    launch(1'b1, 64'hAAAA_AAAA_AAAA_AAAA, 64'hAAAA_AAAA_AAAA_AAAA, 32, 0, 0, 1'b0);
    repeat (48) @(negedge clk);
    s1 = 1'b1;
    @(negedge clk);
    s1 = 1'b0;
    drain();
    repeat (140) @(negedge clk);

    // T6: reset mid-sweep at x_out = 33
    ysel1 = 2'd2;
    @(negedge clk);
    g1 = pla_tab; s1 = 1'b1;
    @(negedge clk);
    s1 = 1'b0;
    wait_x1(6'd33);
    #2 rst_n = 1'b0;
    #1;
    check("t6_x_out", 64'(x1), 64'd0);
    check("t6_busy",  64'(busy1), 64'd0);
    check("t6_done",  64'(done1), 64'd0);
    check("t6_valid", 64'(valid1), 64'd0);
    check("t6_tt",    tt1, 64'd0);
    check("t6_counts", {ones1, err1, mm1, first1}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // T7: clean PLA sweep against its reference table
    launch(1'b1, pla_tab, pla_tab, $countones(pla_tab), 0, 0, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
